// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: load captures a fetched word, squash inserts a bubble
// while keeping the PC fields, otherwise the contents hold.
module fetch_if_id_reg #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_squash,
  input  logic [DATA_WIDTH-1:0]    i_instr,
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  input  logic [ADDRESS_WIDTH-1:0] i_pc_plus4,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_instr,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  output logic [ADDRESS_WIDTH-1:0] o_pc_plus4
);

  logic                     r_valid;
  logic [DATA_WIDTH-1:0]    r_instr;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] r_pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_squash) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives zero-latency instruction memory,
// handles stall/redirect and parks in a sticky fault on misaligned targets.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = FETCH_RESET_PC,
  parameter logic [DATA_WIDTH-1:0]     NOP_INSTR     = FETCH_NOP_INSTR,
  parameter int unsigned               COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
  output logic                     id_valid_o,
  output logic [DATA_WIDTH-1:0]    id_instr_o,
  output logic [ADDRESS_WIDTH-1:0] id_pc_o,
  output logic [ADDRESS_WIDTH-1:0] id_pc_plus4_o,
  output logic                     fault_o,
  output logic [ADDRESS_WIDTH-1:0] fault_pc_o,
  output logic [COUNT_WIDTH-1:0]   fetch_count_o
);

  fetch_state_t             r_state;
  fetch_state_t             w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [ADDRESS_WIDTH-1:0] w_pc_next;
  logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
  logic [ADDRESS_WIDTH-1:0] r_fault_pc;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     w_load;
  logic                     w_squash;
  logic                     w_count_en;
  logic                     w_fault_set;
  logic                     w_misaligned;

  assign w_pc_plus4   = r_pc + ADDRESS_WIDTH'(4);
  assign w_misaligned = |redirect_target_i[1:0];

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_squash     = 1'b0;
    w_count_en   = 1'b0;
    w_fault_set  = 1'b0;
    unique case (r_state)
      BOOT: w_state_next = RUN;
      RUN: begin
        // Redirect beats stall; a misaligned target squashes but never reaches the PC.
        if (redirect_i) begin
          w_squash = 1'b1;
          if (w_misaligned) begin
            w_state_next = FAULT;
            w_fault_set  = 1'b1;
          end else begin
            w_pc_next = redirect_target_i;
          end
        end else if (!stall_i) begin
          w_load     = 1'b1;
          w_pc_next  = w_pc_plus4;
          w_count_en = 1'b1;
        end
      end
      FAULT: w_state_next = FAULT;
      default: w_state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_fault_set) r_fault_pc <= redirect_target_i;
      if (w_count_en)  r_count    <= r_count + COUNT_WIDTH'(1);
    end
  end

  fetch_if_id_reg #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .NOP_INSTR     (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_squash   (w_squash),
    .i_instr    (imem_rdata),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .o_valid    (id_valid_o),
    .o_instr    (id_instr_o),
    .o_pc       (id_pc_o),
    .o_pc_plus4 (id_pc_plus4_o)
  );

  assign imem_addr     = r_pc;
  assign fault_o       = (r_state == FAULT);
  assign fault_pc_o    = r_fault_pc;
  assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default instance plus a RESET_PC=0xFFFF_FFFC
// instance for the address-wrap case.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] target;
  logic [31:0] addr, rdata, id_instr, id_pc, id_pc4, fault_pc, count;
  logic        id_valid, fault;

  logic        b_rst;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc4, b_fault_pc, b_count;
  logic        b_valid, b_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h00A0_0113;
      default:       mem_word = {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endcase
  endfunction

  assign rdata   = mem_word(addr);
  assign b_rdata = mem_word(b_addr);

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .imem_addr         (addr),
    .imem_rdata        (rdata),
    .stall_i           (stall),
    .redirect_i        (redirect),
    .redirect_target_i (target),
    .id_valid_o        (id_valid),
    .id_instr_o        (id_instr),
    .id_pc_o           (id_pc),
    .id_pc_plus4_o     (id_pc4),
    .fault_o           (fault),
    .fault_pc_o        (fault_pc),
    .fetch_count_o     (count)
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk               (clk),
    .rst               (b_rst),
    .imem_addr         (b_addr),
    .imem_rdata        (b_rdata),
    .stall_i           (1'b0),
    .redirect_i        (1'b0),
    .redirect_target_i (32'h0),
    .id_valid_o        (b_valid),
    .id_instr_o        (b_instr),
    .id_pc_o           (b_pc),
    .id_pc_plus4_o     (b_pc4),
    .fault_o           (b_fault),
    .fault_pc_o        (b_fault_pc),
    .fetch_count_o     (b_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_id(input string tag, input if_id_t exp);
    if_id_t obs;
    obs = '{valid: id_valid, instr: id_instr, pc: id_pc, pc_plus4: id_pc4};
    chk({tag, ".valid"},  {31'b0, obs.valid}, {31'b0, exp.valid});
    chk({tag, ".instr"},  obs.instr,    exp.instr);
    chk({tag, ".pc"},     obs.pc,       exp.pc);
    chk({tag, ".pc4"},    obs.pc_plus4, exp.pc_plus4);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    stall = 1'b0; redirect = 1'b0; target = '0;
    #1;
    chk_id("rst", '{1'b0, FETCH_NOP_INSTR, 32'h0, 32'h0});
    chk("rst.addr",  addr,  32'h0);
    chk("rst.fault", {31'b0, fault}, 32'h0);
    chk("rst.fpc",   fault_pc, 32'h0);
    chk("rst.count", count, 32'h0);
    chk("wrap.rst.addr", b_addr, 32'hFFFF_FFFC);
    tick();
    rst = 1'b0;

    // boot edge: no capture, PC held
    tick();
    chk("boot.valid", {31'b0, id_valid}, 32'h0);
    chk("boot.addr", addr, 32'h0);
    tick();
    chk_id("e2", '{1'b1, 32'h0050_0093, 32'h0, 32'h4});
    chk("e2.count", count, 32'd1);
    tick();
    chk_id("e3", '{1'b1, 32'h00A0_0113, 32'h4, 32'h8});
    chk("e3.count", count, 32'd2);
    chk("e3.addr", addr, 32'h8);

    // stall three edges
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.addr", addr, 32'h8);
      chk_id("stall", '{1'b1, 32'h00A0_0113, 32'h4, 32'h8});
      chk("stall.count", count, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk_id("unstall", '{1'b1, mem_word(32'h8), 32'h8, 32'hC});
    chk("unstall.count", count, 32'd3);

    // redirect overrides stall
    redirect = 1'b1; target = 32'h40; stall = 1'b1;
    tick();
    chk_id("redir", '{1'b0, 32'h13, 32'h8, 32'hC});
    chk("redir.addr", addr, 32'h40);
    chk("redir.count", count, 32'd3);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk_id("post_redir", '{1'b1, mem_word(32'h40), 32'h40, 32'h44});
    chk("post_redir.count", count, 32'd4);

    // misaligned redirect -> sticky fault
    redirect = 1'b1; target = 32'h42;
    tick();
    chk("flt.fault", {31'b0, fault}, 32'h1);
    chk("flt.fpc", fault_pc, 32'h42);
    chk_id("flt", '{1'b0, 32'h13, 32'h40, 32'h44});
    chk("flt.addr", addr, 32'h44);
    target = 32'h80;
    tick();
    chk("flt2.addr", addr, 32'h44);
    chk("flt2.fpc", fault_pc, 32'h42);
    redirect = 1'b0;
    tick();
    chk("flt3.fault", {31'b0, fault}, 32'h1);
    chk("flt3.valid", {31'b0, id_valid}, 32'h0);
    chk("flt3.count", count, 32'd4);

    // clear, then walk PC to 0x1C and reset asynchronously mid-redirect
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    redirect = 1'b1; target = 32'h10;
    tick();
    redirect = 1'b0;
    chk("walk.addr0", addr, 32'h10);
    tick(); tick(); tick();
    chk("walk.addr", addr, 32'h1C);
    chk("walk.count", count, 32'd3);
    chk_id("walk", '{1'b1, mem_word(32'h18), 32'h18, 32'h1C});
    redirect = 1'b1; target = 32'h100; stall = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk_id("arst", '{1'b0, FETCH_NOP_INSTR, 32'h0, 32'h0});
    chk("arst.addr", addr, 32'h0);
    chk("arst.count", count, 32'h0);
    chk("arst.fault", {31'b0, fault}, 32'h0);
    tick();
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;
    tick();
    chk("arst.boot.addr", addr, 32'h0);

    // PC wrap instance
    b_rst = 1'b0;
    tick();
    chk("wrap.boot.addr", b_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap.valid", {31'b0, b_valid}, 32'h1);
    chk("wrap.pc", b_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", b_pc4, 32'h0);
    chk("wrap.instr", b_instr, mem_word(32'hFFFF_FFFC));
    chk("wrap.addr", b_addr, 32'h0);
    chk("wrap.count", b_count, 32'd1);
    chk("wrap.fault", {31'b0, b_fault}, 32'h0);
    chk("wrap.fpc", b_fault_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter and drives the memory address.
- It captures the combinational read data into an IF/ID pipeline register for decode.
- It supports stall from the hazard unit and redirect (branch/jump) from execute.
- It detects misaligned redirect targets and parks in a sticky fault state.

Parameters:
- ADDRESS_WIDTH, 32, PC and memory address width.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).
- COUNT_WIDTH, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDRESS_WIDTH  byte address to instruction memory; equals the current PC register.
- imem_rdata  in  DATA_WIDTH  little-endian word returned combinationally by instruction memory.
- stall_i  in  1  hold PC and IF/ID.
- redirect_i  in  1  load redirect_target_i into the PC and squash IF/ID.
- redirect_target_i  in  ADDRESS_WIDTH  new PC.
- id_valid_o  out  1  IF/ID holds a real instruction.
- id_instr_o  out  DATA_WIDTH  captured instruction.
- id_pc_o  out  ADDRESS_WIDTH  PC of the captured instruction.
- id_pc_plus4_o  out  ADDRESS_WIDTH  id_pc_o + 4.
- fault_o  out  1  sticky misaligned-target fault.
- fault_pc_o  out  ADDRESS_WIDTH  offending target.
- fetch_count_o  out  COUNT_WIDTH  number of valid captures since reset.

Behaviour:
- Reset (async, immediate, no clock needed):
  - PC = RESET_PC; state = BOOT.
  - id_valid_o = 0, id_instr_o = NOP_INSTR, id_pc_o = 0, id_pc_plus4_o = 0.
  - fault_o = 0, fault_pc_o = 0, fetch_count_o = 0.
- imem_addr is a purely combinational copy of the PC register. Memory read is zero-latency, so the instruction at PC is captured on the same edge.
- State BOOT: first rising edge after rst deasserts performs no capture and holds the PC, then goes to RUN. stall_i and redirect_i are ignored in BOOT.
- State RUN, per edge, in priority order:
  1. redirect_i=1 with redirect_target_i[1:0]!=0: go to FAULT; fault_pc_o <= target; id_valid_o <= 0; id_instr_o <= NOP_INSTR; PC held.
  2. redirect_i=1 with an aligned target: PC <= target; id_valid_o <= 0; id_instr_o <= NOP_INSTR; id_pc_o and id_pc_plus4_o unchanged. Redirect overrides stall_i.
  3. stall_i=1: PC, IF/ID and fetch_count_o all hold.
  4. Otherwise: capture id_valid_o <= 1, id_instr_o <= imem_rdata, id_pc_o <= PC, id_pc_plus4_o <= PC+4. Then PC <= PC+4 and fetch_count_o++.
- State FAULT: sticky until rst.
  - fault_o = 1 (registered, asserted from the edge that entered FAULT).
  - PC held; id_valid_o = 0; stall_i and redirect_i ignored.
- Arithmetic and wrap:
  - PC+4 is computed modulo 2^ADDRESS_WIDTH, so 0xFFFF_FFFC+4 = 0.
  - fetch_count_o wraps modulo 2^COUNT_WIDTH.
- PC and IF/ID contents are always word-aligned. A misaligned PC is unreachable.
- Reset asserted mid-stall or mid-redirect: reset wins asynchronously and discards any pending redirect.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, FAULT}.
  - NOP_INSTR constant.
  - RESET_PC default.
  - Packed struct if_id_t {valid, instr, pc, pc_plus4}.
- Sub-module fetch_if_id_reg: the IF/ID register with load, hold and squash controls plus async reset. The top level keeps the FSM, PC, counter and fault logic.

Test Plan:
- Reset release, memory word 0x00500093 at 0 and 0x00A00113 at 4 → edge 1: id_valid_o=0, imem_addr=0. Edge 2: id_valid_o=1, id_instr_o=0x00500093, id_pc_o=0, id_pc_plus4_o=4. Edge 3: 0x00A00113, id_pc_o=4, fetch_count_o=2.
- stall_i=1 for 3 edges with PC=0x08 → imem_addr stays 0x08; IF/ID and fetch_count_o unchanged. Release → word at 0x08 captured on the next edge.
- redirect_i=1, target 0x40, with stall_i=1 → next edge: id_valid_o=0, id_instr_o=0x13, imem_addr=0x40. Following edge (no stall): id_pc_o=0x40, id_instr_o = word at 0x40.
- redirect_i=1, target 0x42 → fault_o=1, fault_pc_o=0x42, id_valid_o=0. A later redirect to 0x80 leaves imem_addr unchanged. Only rst clears fault_o.
- Assert rst between edges while PC=0x1C → all outputs take reset values immediately, without a clock edge.
- RESET_PC=0xFFFF_FFFC → first capture gives id_pc_o=0xFFFF_FFFC and id_pc_plus4_o=0; imem_addr becomes 0.
